// File: rtl/load_pkg.sv
// Shared types and decode helpers for the sequential RV32I load unit.
package load_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } load_state_e;

    typedef struct packed {
        logic legal;
        logic misaligned;
        logic crosses;
    } load_chk_t;

    // Legality, natural-alignment and word-crossing classification of one load.
    function automatic load_chk_t load_check(input logic [2:0] funct3, input logic [1:0] off);
        load_chk_t  c;
        logic [2:0] size;
        c.legal      = 1'b0;
        c.misaligned = 1'b0;
        c.crosses    = 1'b0;
        size         = 3'd0;
        case (funct3)
            3'b000, 3'b100: begin
                c.legal = 1'b1;
                size    = 3'd1;
            end
            3'b001, 3'b101: begin
                c.legal      = 1'b1;
                size         = 3'd2;
                c.misaligned = off[0];
            end
            3'b010: begin
                c.legal      = 1'b1;
                size         = 3'd4;
                c.misaligned = (off != 2'b00);
            end
            default: begin
                c.legal = 1'b0;
                size    = 3'd0;
            end
        endcase
        c.crosses = (({1'b0, off} + size) > 3'd4);
        return c;
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Request, memory and writeback channels of the load unit; slave is the unit's view.
interface load_unit_if #(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_opcode;
    logic [2:0]      req_funct3;
    logic [11:0]     req_imm;
    logic [XLEN-1:0] req_base;
    logic [4:0]      req_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_rd;
    logic            rsp_fault;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_imm, req_base, req_rd,
        output req_ready,
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_valid, rsp_data, rsp_rd, rsp_fault,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_imm, req_base, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_valid, rsp_data, rsp_rd, rsp_fault,
        output rsp_ready
    );

endinterface

// File: rtl/load_align.sv
// Byte-lane alignment and sign/zero extension of a loaded word pair.
module load_align
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [63:0]     window_i,
    input  logic [1:0]      off_i,
    input  load_op_e        op_i,
    output logic [XLEN-1:0] result_o
);

    logic [31:0] shifted_s;

    // Shift the addressed byte to lane 0, then extend according to the op.
    always_comb begin
        shifted_s = 32'(window_i >> {off_i, 3'b000});
        result_o  = XLEN'(1'b0);
        case (op_i)
            LB:      result_o = XLEN'($signed(shifted_s[7:0]));
            LH:      result_o = XLEN'($signed(shifted_s[15:0]));
            LW:      result_o = XLEN'($signed(shifted_s));
            LBU:     result_o = XLEN'(shifted_s[7:0]);
            LHU:     result_o = XLEN'(shifted_s[15:0]);
            default: result_o = XLEN'(1'b0);
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Sequential load unit: address generation, one or two word reads, registered extended result.
module load_unit
    import load_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    load_unit_if.slave bus
);

    load_state_e     state_q, state_d;
    logic [XLEN-1:0] ea_q, ea_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            cross_q, cross_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]     word0_q, word0_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_fault_q, rsp_fault_d;

    logic [XLEN-1:0] ea_s;
    logic [XLEN-1:0] word_base_s;
    load_chk_t       chk_s;
    logic [63:0]     window_s;
    logic [XLEN-1:0] align_s;

    assign ea_s        = bus.req_base + XLEN'($signed(bus.req_imm));
    assign chk_s       = load_check(bus.req_funct3, ea_s[1:0]);
    assign word_base_s = {ea_q[XLEN-1:2], 2'b00};
    // The second beat supplies the upper word; single-beat loads see zero above.
    assign window_s    = (state_q == WAIT1) ? {bus.mem_rsp_data, word0_q}
                                            : {32'h0000_0000, bus.mem_rsp_data};

    load_align #(.XLEN(XLEN)) u_align (
        .window_i (window_s),
        .off_i    (ea_q[1:0]),
        .op_i     (load_op_e'(funct3_q)),
        .result_o (align_s)
    );

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_rd        = rd_q;
    assign bus.rsp_fault     = rsp_fault_q;

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        ea_d        = ea_q;
        funct3_d    = funct3_q;
        cross_d     = cross_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        word0_d     = word0_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && (bus.req_opcode == OPC_LOAD)) begin
                    ea_d     = ea_s;
                    funct3_d = bus.req_funct3;
                    cross_d  = chk_s.crosses;
                    rd_d     = bus.req_rd;
                    if (!chk_s.legal || (chk_s.misaligned && !MISALIGNED_EN)) begin
                        state_d     = RESP;
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = XLEN'(1'b0);
                    end else begin
                        state_d     = REQ0;
                        rsp_fault_d = 1'b0;
                        mem_addr_d  = {ea_s[XLEN-1:2], 2'b00};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT0;
                end else begin
                    state_d = REQ0;
                end
            end
            WAIT0: begin
                if (bus.mem_rsp_valid && cross_q && MISALIGNED_EN) begin
                    state_d    = REQ1;
                    word0_d    = bus.mem_rsp_data;
                    mem_addr_d = word_base_s + XLEN'(3'd4);
                end else if (bus.mem_rsp_valid) begin
                    state_d    = RESP;
                    rsp_data_d = align_s;
                end else begin
                    state_d = WAIT0;
                end
            end
            REQ1: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT1;
                end else begin
                    state_d = REQ1;
                end
            end
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    state_d    = RESP;
                    rsp_data_d = align_s;
                end else begin
                    state_d = WAIT1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ea_q        <= XLEN'(1'b0);
            funct3_q    <= 3'b000;
            cross_q     <= 1'b0;
            rd_q        <= 5'd0;
            mem_addr_q  <= XLEN'(1'b0);
            word0_q     <= 32'h0000_0000;
            rsp_data_q  <= XLEN'(1'b0);
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ea_q        <= ea_d;
            funct3_q    <= funct3_d;
            cross_q     <= cross_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            word0_q     <= word0_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Sequential RV32I load unit. Replaces the purely combinational load path.
- Takes one load op per transaction from the execute stage, computes the effective address, and drives a valid/ready word-addressed data-memory port.
- Handles multi-cycle memory latency, correct sign/zero extension, and optional split misaligned loads.
- Returns the extended result to writeback with backpressure.

Parameters:
- XLEN, 32, data/address width (≥32, multiple of 32; extension is to XLEN).
- MISALIGNED_EN, 1, 1 = split word-crossing loads into two beats; 0 = misaligned loads fault.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_opcode  in  7  instruction opcode
- req_funct3  in  3  load width/sign select
- req_imm  in  12  I-type immediate
- req_base  in  XLEN  rs1 value
- req_rd  in  5  destination register tag
- mem_req_valid  out  1  memory read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  word-aligned read address (low 2 bits always 0)
- mem_rsp_valid  in  1  read data valid (in order, one per accepted request, never backpressured)
- mem_rsp_data  in  32  read word
- rsp_valid  out  1  result valid
- rsp_ready  in  1  writeback accepts result
- rsp_data  out  XLEN  extended load result
- rsp_rd  out  5  echoed req_rd
- rsp_fault  out  1  illegal funct3 or misaligned with MISALIGNED_EN=0

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE.
  - req_ready=1; mem_req_valid=0; rsp_valid=0; rsp_fault=0; rsp_data=0; rsp_rd=0; mem_addr=0.
- Reset mid-operation abandons the transaction. mem_rsp_valid is ignored in IDLE, so late responses are dropped.
- Request acceptance:
  - req_ready=1 only in IDLE. Accept on req_valid && req_ready.
  - req_opcode != 7'b0000011: accepted and dropped, no response.
- Effective address: ea = req_base + sign-extended req_imm, mod 2^XLEN. Registered at accept. off = ea[1:0].
- funct3 decode:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011/110/111: fault.
- Misalignment:
  - LH/LHU with off[0]=1 is misaligned.
  - LW with off!=0 is misaligned.
  - A load crosses a word boundary when off+size>4 (LH off=3, LW off 1..3).
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE → RESP: illegal funct3, or misaligned with MISALIGNED_EN=0. Fault response, rsp_data=0, no memory access.
  - IDLE → REQ0: otherwise. mem_addr = ea & ~3.
  - REQ0 → WAIT0: on mem_req_valid && mem_req_ready.
  - WAIT0 → REQ1 on mem_rsp_valid if the load crosses a word boundary and MISALIGNED_EN=1. Latch word0; mem_addr = (ea & ~3) + 4, wrapping mod 2^XLEN.
  - WAIT0 → RESP on mem_rsp_valid otherwise.
  - REQ1 → WAIT1: on handshake.
  - WAIT1 → RESP: on mem_rsp_valid. Latch word1.
  - RESP → IDLE: on rsp_ready. rsp_* hold stable while rsp_valid && !rsp_ready.
- mem_req_valid=1 exactly in REQ0/REQ1. Held with a stable mem_addr until handshake.
- Data extraction:
  - window = {word1, word0} >> (8*off); word1=0 for single-beat loads.
  - LB/LH sign-extend bit 7/15 to XLEN. LBU/LHU zero-extend. LW sign-extends bit 31 when XLEN>32.
- Result is registered. rsp_valid rises the cycle after the final mem_rsp_valid.
- Minimum aligned latency, with zero-wait memory returning a response the cycle after handshake:
  - accept at edge T, mem handshake at T+1, response at T+2, rsp_valid at T+3.
- rsp_valid and rsp_fault are mutually consistent: rsp_fault is only meaningful when rsp_valid=1.

Decomposition:
- Package load_pkg:
  - OPC_LOAD constant.
  - funct3 enum load_op_e (LB, LH, LW, LBU, LHU).
  - FSM enum load_state_e.
  - Helper function for the misaligned/cross-word check.
- Sub-module load_align: combinational. Inputs window, off, op; output XLEN extended result.

Test Plan:
- Sign-extension: word@0x1000=0x80123456, base=0x1000.
  - imm=3: LB → 0xFFFFFF80, LBU → 0x00000080.
  - imm=2: LH → 0xFFFF8012, LHU → 0x00008012.
  - Exactly one mem request at 0x1000.
- Negative immediate: base=0x1004, imm=0xFFC, LW, word@0x1000=0xDEADBEEF.
  - mem_addr=0x1000, rsp_data=0xDEADBEEF, rsp_rd echoed, latency T+3 with zero-wait memory.
- Split load, MISALIGNED_EN=1: base=0x1002, LW, word@0x1000=0x44332211, word@0x1004=0x88776655.
  - Requests 0x1000 then 0x1004; rsp_data=0x66554433.
  - Same setup with base=0x1003, LH → 0x00005544 (sign bit clear).
- Faults:
  - MISALIGNED_EN=0, LW at 0x1001 → rsp_fault=1, rsp_data=0, mem_req_valid never asserted.
  - funct3=011 → fault.
  - Opcode 0x13 → no response.
- Backpressure:
  - mem_req_ready low 4 cycles → mem_addr stable.
  - rsp_ready low 3 cycles → rsp_valid/data stable, req_ready=0, second request not accepted until RESP handshake.
- Reset mid-op: assert rst in WAIT0, then deliver mem_rsp_valid the next cycle.
  - Outputs at reset values, no rsp_valid.
  - A new LW completes correctly afterwards.
